// File: rtl/ycocg_dram_write_packer.sv
// Packs 16-bit YCoCg words into WORDS_PER_BEAT-wide DRAM beats and queues them in a FWFT FIFO.
// Optional: define PACKER_PARTIAL_FLUSH_EN to push a zero-padded partial beat on frame_start.
module ycocg_dram_write_packer #(
  parameter int WORDS_PER_BEAT = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int FRAME_BEATS    = 115200,
  parameter int ADDR_W         = 17
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pixel_valid,
  input  logic [15:0]                    pixel_data,
  input  logic                           frame_start,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [16*WORDS_PER_BEAT-1:0]   wr_data,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow
);

  localparam int KW = $clog2(WORDS_PER_BEAT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = 16 * WORDS_PER_BEAT;

  logic [KW-1:0]     k_q, k_d, k_eff;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_eff;
  logic [BW-1:0]     asm_q, asm_d, asm_new;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              fs, complete, flush, push, pop, push_ok;
  logic [BW-1:0]     push_data;
  logic [ADDR_W-1:0] push_addr;

  logic [BW-1:0]     mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];

  always_comb begin
    fs       = pixel_valid && frame_start;
    k_eff    = fs ? '0 : k_q;
    addr_eff = fs ? '0 : addr_q;
    asm_new  = fs ? '0 : asm_q;
    for (int unsigned i = 0; i < WORDS_PER_BEAT; i++) begin
      if (k_eff == KW'(i)) asm_new[16*i +: 16] = pixel_data;
    end
    complete = pixel_valid && (k_eff == KW'(WORDS_PER_BEAT - 1));
`ifdef PACKER_PARTIAL_FLUSH_EN
    flush = fs && (k_q != '0);
`else
    flush = 1'b0;
`endif
    // A flush can never coincide with completion: the frame_start word lands in slice 0.
    push      = complete || flush;
    push_data = complete ? asm_new : asm_q;
    push_addr = complete ? addr_eff : addr_q;

    asm_d  = asm_q;
    k_d    = k_q;
    addr_d = addr_q;
    if (pixel_valid) begin
      // Assembly is cleared after each beat so a flushed partial beat is zero-padded.
      asm_d = complete ? '0 : asm_new;
      k_d   = complete ? '0 : k_eff + KW'(1);
      if (complete) addr_d = (addr_eff == ADDR_W'(FRAME_BEATS - 1)) ? '0 : addr_eff + ADDR_W'(1);
      else          addr_d = addr_eff;
    end

    pop        = wr_valid && wr_ready;
    push_ok    = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    wptr_d     = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    overflow_d = overflow_q || (push && !push_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q        <= '0;
      addr_q     <= '0;
      asm_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      addr_q     <= addr_d;
      asm_q      <= asm_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data_q[wptr_q] <= push_data;
      mem_addr_q[wptr_q] <= push_addr;
    end
  end

  // Head is gated so outputs read zero whenever the FIFO is empty, including reset.
  assign wr_valid   = (count_q != '0);
  assign wr_data    = wr_valid ? mem_data_q[rptr_q] : '0;
  assign wr_addr    = wr_valid ? mem_addr_q[rptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ycocg_dram_write_packer.sv
// Scoreboard bench for ycocg_dram_write_packer; frame length is shortened to keep the wrap test brief.
module tb_ycocg_dram_write_packer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FB = 24;
  localparam int AW = 17;

  typedef struct {
    logic [16*W-1:0] d;
    logic [AW-1:0]   a;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pixel_valid, frame_start, wr_ready;
  logic [15:0]       pixel_data;
  logic              wr_valid, overflow;
  logic [16*W-1:0]   wr_data;
  logic [AW-1:0]     wr_addr;
  logic [$clog2(D):0] fifo_count;

  int errors = 0;
  int checks = 0;

  beat_t       sb[$];
  logic [15:0] masm [W];
  int          mk;
  int          maddr;
  logic        exp_ovf;
  int          last_addr, prev_addr;

  ycocg_dram_write_packer #(
    .WORDS_PER_BEAT(W), .FIFO_DEPTH(D), .FRAME_BEATS(FB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [16*W-1:0] pack_model();
    logic [16*W-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) b[16*i +: 16] = masm[i];
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < W; i++) masm[i] = 16'h0;
  endtask

  task automatic model_push(input logic [16*W-1:0] d, input int a);
    beat_t e;
    e.d = d;
    e.a = AW'(a);
    if (sb.size() < D) sb.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_reset();
    sb.delete();
    mk = 0;
    maddr = 0;
    exp_ovf = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs at negedge, check the head, update the model, check state after the edge.
  task automatic step(input logic pv, input logic fs, input logic [15:0] d, input logic rdy);
    beat_t e;
    pixel_valid = pv; frame_start = fs; pixel_data = d; wr_ready = rdy;
    #1;
    checks++;
    if (wr_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL wr_valid: got %b exp %b", wr_valid, sb.size() != 0);
    end
    if (sb.size() != 0 && rdy) begin
      e = sb.pop_front();
      checks += 2;
      if (wr_data !== e.d) begin
        errors++;
        $display("FAIL wr_data: got %h exp %h", wr_data, e.d);
      end
      if (wr_addr !== e.a) begin
        errors++;
        $display("FAIL wr_addr: got %0d exp %0d", wr_addr, e.a);
      end
      prev_addr = last_addr;
      last_addr = int'(wr_addr);
    end
    if (pv) begin
      if (fs) begin
`ifdef PACKER_PARTIAL_FLUSH_EN
        if (mk != 0) model_push(pack_model(), maddr);
`endif
        mk = 0;
        maddr = 0;
        model_clear();
      end
      masm[mk] = d;
      if (mk == W - 1) begin
        model_push(pack_model(), maddr);
        maddr = (maddr == FB - 1) ? 0 : maddr + 1;
        mk = 0;
        model_clear();
      end else begin
        mk++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0; frame_start = 1'b0;
    checks += 2;
    if (fifo_count !== ($clog2(D)+1)'(sb.size())) begin
      errors++;
      $display("FAIL fifo_count: got %0d exp %0d", fifo_count, sb.size());
    end
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow: got %b exp %b", overflow, exp_ovf);
    end
  endtask

  task automatic do_reset();
    pixel_valid = 1'b0; frame_start = 1'b0; pixel_data = '0; wr_ready = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pixel_valid = 1'b0; frame_start = 1'b0; pixel_data = '0; wr_ready = 1'b0;
    model_reset();
    #3;
    checks += 5;
    if (wr_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b exp 0", wr_valid); end
    if (wr_data !== '0)     begin errors++; $display("FAIL rst_data: got %h exp 0", wr_data); end
    if (wr_addr !== '0)     begin errors++; $display("FAIL rst_addr: got %0d exp 0", wr_addr); end
    if (fifo_count !== '0)  begin errors++; $display("FAIL rst_count: got %0d exp 0", fifo_count); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %b exp 0", overflow); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_beat();
    logic [16*W-1:0] exp_beat;
    exp_beat = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    for (int i = 1; i <= W; i++) step(1'b1, 1'b0, 16'(i), 1'b0);
    #1;
    checks += 2;
    if (wr_data !== exp_beat) begin
      errors++; $display("FAIL basic_data: got %h exp %h", wr_data, exp_beat);
    end
    if (wr_addr !== '0) begin
      errors++; $display("FAIL basic_addr: got %0d exp 0", wr_addr);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6 * W; i++) step(1'b1, 1'b0, 16'(16'h100 + i), 1'b0);
    drain();
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 16'(16'h300 + i), 1'b0);
    #1;
    checks++;
    if (wr_addr !== AW'(6)) begin
      errors++; $display("FAIL ovf_next_addr: got %0d exp 6", wr_addr);
    end
    drain();
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < D * W + W - 1; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0);
    step(1'b1, 1'b0, 16'($urandom), 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    drain();
  endtask

  task automatic test_frame_wrap();
    do_reset();
    last_addr = -1; prev_addr = -1;
    for (int i = 0; i < FB * W + W; i++) step(1'b1, 1'b0, 16'($urandom), 1'b1);
    drain();
    checks += 2;
    if (prev_addr != FB - 1) begin
      errors++; $display("FAIL wrap_last: got %0d exp %0d", prev_addr, FB - 1);
    end
    if (last_addr != 0) begin
      errors++; $display("FAIL wrap_next: got %0d exp 0", last_addr);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h500 + i), 1'b1);
    drain();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h700 + i), 1'b1);
    step(1'b1, 1'b1, 16'hAAAA, 1'b1);
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, 16'(16'h800 + i), 1'b1);
    step(1'b0, 1'b1, 16'hBBBB, 1'b1);
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < W + 5; i++) step(1'b1, 1'b0, 16'(16'h900 + i), 1'b0);
    #1;
    checks++;
    if (wr_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b exp 1", wr_valid); end
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (wr_valid !== 1'b0)  begin errors++; $display("FAIL arst_valid: got %b exp 0", wr_valid); end
    if (wr_data !== '0)     begin errors++; $display("FAIL arst_data: got %h exp 0", wr_data); end
    if (wr_addr !== '0)     begin errors++; $display("FAIL arst_addr: got %0d exp 0", wr_addr); end
    if (fifo_count !== '0)  begin errors++; $display("FAIL arst_count: got %0d exp 0", fifo_count); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 16'(16'hC00 + i), 1'b1);
    drain();
  endtask

  initial begin
    last_addr = -1; prev_addr = -1;
    test_reset();
    test_basic_beat();
    test_overflow();
    test_full_push_pop();
    test_frame_wrap();
    test_frame_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
